// File: rtl/mnist_image_reader.sv
// Streams the 28x28 image out of image_memory one pixel per valid/ready handshake, in raster order.
// Optional build macro MNIST_BINARIZE_EN: emit PIX_ONE for non-zero words, zero otherwise.
module mnist_image_reader #(
   parameter int                 GRID_SIZE = 28,
   parameter logic [15:0]        BASE_ADDR = 16'd0,
   parameter int                 READ_LAT  = 1,
   parameter logic signed [31:0] PIX_ONE   = 32'sd65536
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   output logic [15:0]        read_addr,
   input  logic signed [31:0] mem_data,
   output logic signed [31:0] pix_data,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [9:0]         pix_index,
   output logic               pix_last,
   output logic               busy,
   output logic               done
);

   localparam int         NPIX     = GRID_SIZE * GRID_SIZE;
   localparam logic [9:0] LAST_IDX = 10'(NPIX - 1);
   localparam int         LAT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

`ifdef MNIST_BINARIZE_EN
   localparam bit BINARIZE = 1'b1;
`else
   localparam bit BINARIZE = 1'b0;
`endif

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ISSUE   = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_PRESENT = 3'd3;
   localparam logic [2:0] S_FINISH  = 3'd4;

   logic [2:0]         state_q, state_d;
   logic [9:0]         idx_q, idx_d;
   logic [15:0]        addr_q, addr_d;
   logic signed [31:0] data_q, data_d;
   logic               valid_q, valid_d;
   logic               last_q, last_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [LAT_W-1:0]   cnt_q, cnt_d;
   logic signed [31:0] cap_val;

   assign cap_val = BINARIZE ? ((mem_data != 32'sd0) ? PIX_ONE : 32'sd0) : mem_data;

   // read_addr is loaded on entry to ISSUE so the memory sees it for the whole ISSUE cycle.
   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ISSUE;
               idx_d   = 10'd0;
               addr_d  = BASE_ADDR;
               busy_d  = 1'b1;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == LAT_LAST) begin
               data_d  = cap_val;
               valid_d = 1'b1;
               last_d  = (idx_q == LAST_IDX);
               state_d = S_PRESENT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PRESENT: begin
            if (pix_ready) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               if (idx_q == LAST_IDX) begin
                  done_d  = 1'b1;
                  state_d = S_FINISH;
               end else begin
                  idx_d   = idx_q + 10'd1;
                  addr_d  = BASE_ADDR + {6'd0, idx_q + 10'd1};
                  state_d = S_ISSUE;
               end
            end
         end
         S_FINISH: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= 10'd0;
         addr_q  <= BASE_ADDR;
         data_q  <= 32'sd0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign read_addr = addr_q;
   assign pix_data  = data_q;
   assign pix_valid = valid_q;
   assign pix_index = idx_q;
   assign pix_last  = last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_mnist_image_reader.sv
// Self-checking bench for mnist_image_reader: image_memory model with 1-cycle read latency,
// reference pixel stream computed from the memory contents and handshake count.
module tb_mnist_image_reader;

   localparam int BASE_A = 0;
   localparam int BASE_B = 100;

   logic               CLOCK_50 = 1'b0;
   logic               reset;
   logic               start, start_b;
   logic               pix_ready, ready_b;
   logic [15:0]        read_addr, read_addr_b;
   logic signed [31:0] mem_data, mem_data_b;
   logic signed [31:0] pix_data, pix_data_b;
   logic               pix_valid, pix_valid_b;
   logic [9:0]         pix_index, pix_index_b;
   logic               pix_last, pix_last_b;
   logic               busy, busy_b;
   logic               done, done_b;

   logic signed [31:0] mem [0:1023];

   int total = 0;
   int bad   = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      mem_data   <= mem[read_addr[9:0]];
      mem_data_b <= mem[read_addr_b[9:0]];
   end

   mnist_image_reader dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
      .read_addr(read_addr), .mem_data(mem_data),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_index(pix_index), .pix_last(pix_last), .busy(busy), .done(done)
   );

   mnist_image_reader #(.BASE_ADDR(16'd100)) dut_b (
      .CLOCK_50(CLOCK_50), .reset(reset), .start(start_b),
      .read_addr(read_addr_b), .mem_data(mem_data_b),
      .pix_data(pix_data_b), .pix_valid(pix_valid_b), .pix_ready(ready_b),
      .pix_index(pix_index_b), .pix_last(pix_last_b), .busy(busy_b), .done(done_b)
   );

   function automatic logic signed [31:0] ref_pix(input logic signed [31:0] m);
`ifdef MNIST_BINARIZE_EN
      return (m != 32'sd0) ? 32'sd65536 : 32'sd0;
`else
      return m;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_read_addr"}, read_addr, BASE_A);
      check({tag, "_pix_data"},  pix_data, 0);
      check({tag, "_pix_valid"}, pix_valid, 0);
      check({tag, "_pix_index"}, pix_index, 0);
      check({tag, "_pix_last"},  pix_last, 0);
      check({tag, "_busy"},      busy, 0);
      check({tag, "_done"},      done, 0);
   endtask

   // One frame on dut; called at a negedge. Pixel n must carry ref_pix(mem[BASE_A+n]).
   task automatic run_frame(input int stall_pix, input int stall_len, input int poke_pix,
                            input bit rnd_ready, input bit start_at_done);
      int n = 0;
      int stalled = 0;
      int first_valid = -1;
      int done_cyc = -1;
      int dones = 0;
      bit prev_valid = 1'b0;
      bit prev_hs = 1'b0;
      start = 1'b1;
      for (int c = 0; c < 20000 && dones == 0; c++) begin
         @(negedge CLOCK_50);
         start = 1'b0;
         if (prev_valid && !prev_hs) check("valid_held", pix_valid, 1);
         if (prev_hs) check("valid_drop", pix_valid, 0);
         if (pix_valid && first_valid < 0) first_valid = c;
         if (done) begin
            dones++;
            done_cyc = c;
            check("done_after_last_hs", prev_hs, 1);
            check("done_pixels", n, 784);
            check("busy_at_done", busy, 1);
            if (start_at_done) start = 1'b1;
         end
         prev_hs = 1'b0;
         prev_valid = pix_valid;
         if (pix_valid) begin
            check("pix_data", pix_data, ref_pix(mem[BASE_A + n]));
            check("pix_index", pix_index, n);
            check("pix_last", pix_last, n == 783);
            check("read_addr", read_addr, BASE_A + n);
            check("busy", busy, 1);
            if (n == poke_pix) start = 1'b1;
            if (n == stall_pix && stalled < stall_len) begin
               pix_ready = 1'b0;
               stalled++;
            end else begin
               pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (pix_ready) begin
               prev_hs = 1'b1;
               n++;
            end
         end else begin
            pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
      check("frame_pixels", n, 784);
      check("frame_dones", dones, 1);
      check("first_valid_latency", first_valid, 2);
      if (!rnd_ready) check("done_cycle", done_cyc, 2352 + stall_len);
      @(negedge CLOCK_50);
      start = 1'b0;
      check("post_busy", busy, 0);
      check("post_done", done, 0);
      check("post_valid", pix_valid, 0);
      @(negedge CLOCK_50);
      check("post_busy2", busy, 0);
   endtask

   initial begin
      bit hit;
      int nb, first_b, last_b;
      bit seen_b;
      logic signed [31:0] data0_b, datal_b;

      reset = 1'b1;
      start = 1'b0;
      start_b = 1'b0;
      pix_ready = 1'b0;
      ready_b = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = i;
      repeat (3) @(negedge CLOCK_50);
      check_reset_outputs("rst");
      check("rst_b_read_addr", read_addr_b, BASE_B);
      reset = 1'b0;
      @(negedge CLOCK_50);
      check_reset_outputs("idle");

      // Plain frame with mem[i]=i; start is also pulsed alongside the done pulse.
      run_frame(-1, 0, -1, 1'b0, 1'b1);

      // Random image with spot values, 10-cycle stall on pixel 5, stray start at pixel 100.
      for (int i = 0; i < 1024; i++)
         mem[i] = ($urandom_range(0, 2) == 0) ? 32'sd0 :
                  ($urandom_range(0, 1) == 0) ? 32'sd1 : $signed($urandom);
      mem[0] = 32'sd1;
      mem[1] = 32'sd0;
      mem[2] = -32'sd7;
      run_frame(5, 10, 100, 1'b0, 1'b0);

      // Random backpressure throughout.
      run_frame(-1, 0, -1, 1'b1, 1'b0);

      // Reset while pixel 300 is presented.
      hit = 1'b0;
      start = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge CLOCK_50);
         start = 1'b0;
         pix_ready = 1'b1;
         if (pix_valid && pix_index == 10'd300) begin
            hit = 1'b1;
            break;
         end
      end
      check("reach_pixel_300", hit, 1);
      pix_ready = 1'b0;
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      @(negedge CLOCK_50);
      reset = 1'b0;
      pix_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLOCK_50);
         check("after_rst_done", done, 0);
         check("after_rst_busy", busy, 0);
      end
      run_frame(-1, 0, -1, 1'b0, 1'b0);

      // Offset base address instance.
      nb = 0;
      first_b = -1;
      last_b = -1;
      seen_b = 1'b0;
      data0_b = 32'sd0;
      datal_b = 32'sd0;
      start_b = 1'b1;
      ready_b = 1'b1;
      for (int c = 0; c < 4000 && !seen_b; c++) begin
         @(negedge CLOCK_50);
         start_b = 1'b0;
         if (pix_valid_b) begin
            if (nb == 0) begin
               first_b = int'(read_addr_b);
               data0_b = pix_data_b;
            end
            last_b = int'(read_addr_b);
            datal_b = pix_data_b;
            nb++;
         end
         if (done_b) seen_b = 1'b1;
      end
      check("b_done_seen", seen_b, 1);
      check("b_pixels", nb, 784);
      check("b_first_addr", first_b, BASE_B);
      check("b_last_addr", last_b, BASE_B + 783);
      check("b_first_data", data0_b, ref_pix(mem[BASE_B]));
      check("b_last_data", datal_b, ref_pix(mem[BASE_B + 783]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
